// File: rtl/top_core_pkg.sv
// Shared constants and helpers for the top_core serial-to-parallel collector.
package top_core_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Direction encodings seen on l2b
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/top_core_rx_majority_filter.sv
// 3-tap majority filter on the synchronized serial bit. Rejects single-cycle
// glitches and adds two edges of latency (tap register plus output register).
module rx_majority_filter (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [2:0] r_taps;
    logic       r_q;

    // Tap shift register and registered 2-of-3 vote
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps <= '0;
            r_q    <= 1'b0;
        end else begin
            r_taps <= {r_taps[1:0], i_d};
            r_q    <= (r_taps[0] & r_taps[1]) |
                      (r_taps[0] & r_taps[2]) |
                      (r_taps[1] & r_taps[2]);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/top_core.sv
// top_core: serial-to-parallel collector. rx is synchronized, shifted into a
// WIDTH-bit frame in the direction chosen by l2b, and each full frame is
// latched into a holding register driven onto test when oe is high.
// Optional build macro TOP_CORE_RX_FILTER_EN inserts a 3-sample majority
// filter after the synchronizer (two extra edges of latency and warm-up).
module top_core
    import top_core_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l2b,
    input  logic             oe,
    input  logic             rx,
    output logic [WIDTH-1:0] test
);

`ifdef TOP_CORE_RX_FILTER_EN
    localparam int WARM = SYNC_STAGES + 2;
`else
    localparam int WARM = SYNC_STAGES;
`endif
    localparam int VC_W  = clog2(WARM + 1);
    localparam int CNT_W = clog2(WIDTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [VC_W-1:0]        r_valid_cnt;
    logic [WIDTH-1:0]       r_sr;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_l2b_q;

    logic                   w_rx_s;
    logic                   w_rx_f;
    logic                   w_en;
    logic                   w_dir_chg;
    logic                   w_last;
    logic [WIDTH-1:0]       w_sr_nxt;

    // Synchronizer chain for the asynchronous rx input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(rx);
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef TOP_CORE_RX_FILTER_EN
    rx_majority_filter u_filter (
        .clk (clk),
        .rst (rst),
        .i_d (w_rx_s),
        .o_q (w_rx_f)
    );
`else
    assign w_rx_f = w_rx_s;
`endif

    // Warm-up counter: holds off shifting until the reset zeros have drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_cnt <= '0;
        end else if (r_valid_cnt != VC_W'(WARM)) begin
            r_valid_cnt <= r_valid_cnt + 1'b1;
        end
    end

    assign w_en      = (r_valid_cnt == VC_W'(WARM));
    assign w_dir_chg = (l2b != r_l2b_q);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Next shift-register value for the current direction
    always_comb begin
        w_sr_nxt = r_sr;
        if (l2b == DIR_LSB_FIRST) begin
            w_sr_nxt = {w_rx_f, r_sr[WIDTH-1:1]};
        end else begin
            w_sr_nxt = {r_sr[WIDTH-2:0], w_rx_f};
        end
    end

    // Frame assembly; a direction change drops the partial frame and this bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_l2b_q <= 1'b0;
        end else begin
            r_l2b_q <= l2b;
            if (w_dir_chg) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else if (w_en) begin
                r_sr <= w_sr_nxt;
                if (w_last) begin
                    r_cnt  <= '0;
                    r_hold <= w_sr_nxt;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign test = oe ? r_hold : '0;

endmodule

// File: tb/tb_top_core.sv
// Directed self-checking bench for top_core (WIDTH=8, SYNC_STAGES=2).
// Edge numbers in the comments count rising edges after reset is released.
module tb_top_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       l2b;
    logic       oe;
    logic       rx;
    logic [7:0] test;

    int n_checks = 0;
    int n_fail   = 0;

    top_core #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .l2b  (l2b),
        .oe   (oe),
        .rx   (rx),
        .test (test)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        rx  = 1'b0;
        tick();
        check(tag, test, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic lsb_first);
        for (int i = 0; i < 8; i++) begin
            drive_bit(lsb_first ? v[i] : v[7-i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] v2;
        rst = 1'b1;
        oe  = 1'b1;
        l2b = 1'b0;
        rx  = 1'b0;
        tick();
        tick();

`ifndef TOP_CORE_RX_FILTER_EN
        do_reset("reset");
        // Frame 0xB2 on edges 1..8, completes at edge 10
        send_byte(8'hB2, 1'b0);
        check("warmup_no_frame", test, 8'h00);
        v2 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            drive_bit(v2[7-i]);
            if (i == 0) check("b2_early", test, 8'h00);
            if (i == 1) begin
                check("b2_frame", test, 8'hB2);
                oe = 1'b0;
                #1;
                check("oe_off", test, 8'h00);
                oe = 1'b1;
                #1;
                check("oe_on", test, 8'hB2);
            end
        end
        // Back-to-back frame 0x3C completes at edge 18
        drive_bit(1'b1);
        check("b2b_hold", test, 8'hB2);
        drive_bit(1'b1);
        check("b2b_frame", test, 8'h3C);
        drive_bit(1'b0);
        do_reset("rst_mid");

        send_byte(8'h55, 1'b0);
        drive_bit(1'b0);
        check("f55_early", test, 8'h00);
        drive_bit(1'b0);
        check("f55_frame", test, 8'h55);

        do_reset("reset_l2b");
        l2b = 1'b1;
        send_byte(8'h4D, 1'b1);
        drive_bit(1'b0);
        check("f4d_early", test, 8'h00);
        drive_bit(1'b0);
        check("f4d_frame", test, 8'h4D);

        // Direction flips at edge 6; eight 1s then complete at edge 14
        do_reset("reset_dir");
        l2b = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        l2b = 1'b1;
        for (int e = 6; e <= 14; e++) begin
            drive_bit(1'b1);
            if (e < 14) check($sformatf("dir_nopartial_e%0d", e), test, 8'h00);
            else        check("dir_ff", test, 8'hFF);
        end
        oe = 1'b0;
        #1;
        check("dir_oe_off", test, 8'h00);
        oe = 1'b1;
`else
        // Filter build: latency 4, first sample votes against reset zeros
        do_reset("reset_f");
        l2b = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            drive_bit((e == 12) ? 1'b0 : 1'b1);
            if (e == 11) check("f_warm", test, 8'h00);
            if (e == 12) check("f_first_frame", test, 8'h7F);
            if (e == 20) check("f_glitch_in_ones", test, 8'hFF);
        end
        do_reset("reset_f2");
        for (int e = 1; e <= 12; e++) begin
            drive_bit(e == 4);
            if (e == 12) check("f_glitch_in_zeros", test, 8'h00);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_core.md
Name: top_core

Overview:
- Serial-to-parallel collector. Samples a 1-bit serial input `rx` every clock and assembles frames of WIDTH bits.
- Shift direction is selectable at run time through `l2b`.
- Each completed frame is latched into a holding register.
- The holding register is presented on the parallel output `test`, gated by the output enable `oe`.
- Used as the top-level data-capture block feeding parallel consumers.

Parameters:
- WIDTH, 8, frame and output width in bits (≥2).
- SYNC_STAGES, 2, number of rx synchronizer flops (≥1).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- l2b  input  1  direction select: 0 = first-received bit lands in the MSB; 1 = first-received bit lands in the LSB.
- oe   input  1  output enable for `test`.
- rx   input  1  serial data, asynchronous to clk.
- test output WIDTH  parallel frame output.

Interface: one clock; reset is synchronous and active-high (ports `clk`, `rst`).

Behaviour:
- Reset (rst=1 at an edge) clears all of the following to 0: synchronizer flops, `valid_cnt`, shift register `sr`, bit counter `cnt`, `hold`, `l2b_q`. Output `test` = 0.
- Synchronizer:
  - rx passes through SYNC_STAGES flops to give `rx_s`.
  - A warm-up counter `valid_cnt` inhibits shifting and counting for the first SYNC_STAGES edges after reset. Reset zeros never enter a frame.
  - Latency: an rx value present before edge t enters `sr` at edge t+SYNC_STAGES.
- Shift rule, per enabled edge:
  - l2b=0: sr <= {sr[WIDTH-2:0], rx_s}.
  - l2b=1: sr <= {rx_s, sr[WIDTH-1:1]}.
  - cnt increments each enabled edge.
- Frame completion:
  - At the edge where cnt==WIDTH-1: hold <= the next value of sr (the complete frame), and cnt <= 0.
  - Frames are back-to-back with no idle gap.
- Direction change:
  - `l2b_q` registers l2b every edge.
  - On an edge where l2b != l2b_q: sr <= 0, cnt <= 0, the current rx_s bit is discarded, and hold is unchanged.
  - The first bit of the next frame is rx_s at the following edge.
- Output:
  - test = oe ? hold : 0. This path is combinational from oe, with no added latency.
  - hold is retained while oe=0.
- Reset asserted mid-frame: the partial frame is lost, hold=0, and warm-up restarts.
- oe and l2b are used unsynchronized; they are expected to be quasi-static.

Optional Feature:
- Macro: TOP_CORE_RX_FILTER_EN.
- Defined:
  - rx_s is fed through a 3-sample majority filter: out = majority of the last 3 rx_s samples.
  - Sample-pipeline latency increases by 2 edges.
  - Warm-up becomes SYNC_STAGES+2 edges.
  - Single-cycle glitches are rejected.
- Undefined: rx_s goes directly to the shifter; the filter logic is absent.

Decomposition:
- Package top_core_pkg holds:
  - WIDTH_DEF = 8;
  - SYNC_STAGES_DEF = 2;
  - the function clog2 used for the width of cnt;
  - localparams for the direction encodings DIR_MSB_FIRST = 0 and DIR_LSB_FIRST = 1.
- One sub-module: rx_majority_filter. It is 3-tap, synchronous-reset, and is instantiated only under TOP_CORE_RX_FILTER_EN.

Test Plan:
- Reset → test=0x00 with oe=1; no frame completes during warm-up.
- oe=1, l2b=0, rx serial 1,0,1,1,0,0,1,0 (one bit per clock) → test=0xB2 exactly SYNC_STAGES+8 edges after the first bit.
- oe=1, l2b=1, same bits → test=0x4D.
- After the frame 0xB2, oe=0 → test=0x00. Then oe=1 → test=0xB2 immediately, with no new frame needed.
- l2b toggled after 3 bits, then eight 1s → test=0xFF. No partial-frame value ever appears on test.
- rst pulsed mid-frame → test=0x00. The next 8 bits 0,1,0,1,0,1,0,1 with l2b=0 → test=0x55. With TOP_CORE_RX_FILTER_EN, a 1-cycle rx glitch inside a constant-0 frame yields test=0x00.
